// File: rtl/nibble_add_sched.sv
// -----------------------------------------------------------------------------
// nibble_add_sched
//
// Two-requester adder that reuses one 4-bit ripple-adder stage over NIBBLES
// clock cycles. A round-robin arbiter accepts one add at a time. The winner's
// operands are latched, and the add is carried out one nibble per cycle. The
// result is then published on SUM/COUT/OWNER with a one-cycle DONE pulse.
//
// Timing: GNTx is high in cycle c, BUSY is high in cycles c..c+NIBBLES-1, and
// DONE is high in cycle c+NIBBLES. A new request can be accepted on the DONE
// cycle's edge, giving one add every NIBBLES+1 cycles.
//
// Parameters
//   NIBBLES   number of 4-bit passes (2..8); operand width W = 4*NIBBLES
//
// Optional feature
//   NIBBLE_ADD_SCHED_OVF_EN  when defined, adds the OVF output. OVF is the
//                            signed overflow of the last completed add.
//
// Ports
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   REQ0/REQ1    level add requests
//   OPA0/OPA1    addend A per requester (W bits)
//   OPB0/OPB1    addend B per requester (W bits)
//   CIN0/CIN1    carry-in per requester
//   GNT0/GNT1    one-cycle accept pulses
//   BUSY         high while a nibble pass is in progress
//   SUM          result of the last completed add (W bits)
//   COUT         carry-out of bit W-1 of the last completed add
//   OWNER        requester index of the last completed add
//   DONE         one-cycle pulse when SUM/COUT/OWNER update
//   OVF          (optional) signed overflow, held with SUM
// -----------------------------------------------------------------------------
module nibble_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   REQ0,
    input  logic [4*NIBBLES-1:0]   OPA0,
    input  logic [4*NIBBLES-1:0]   OPB0,
    input  logic                   CIN0,
    input  logic                   REQ1,
    input  logic [4*NIBBLES-1:0]   OPA1,
    input  logic [4*NIBBLES-1:0]   OPB1,
    input  logic                   CIN1,
    output logic                   GNT0,
    output logic                   GNT1,
    output logic                   BUSY,
    output logic [4*NIBBLES-1:0]   SUM,
    output logic                   COUT,
    output logic                   OWNER,
    output logic                   DONE
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    ,
    output logic                   OVF
`endif
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     nidx_q, nidx_d;
    logic           cr_q, cr_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   wrk_q, wrk_d;
    logic           cur_q, cur_d;       // requester being served
    logic           rr_last_q, rr_last_d;   // requester granted most recently
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done_q, done_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           owner_q, owner_d;

    logic           accept_s;
    logic           win_s;
    logic           last_nib_s;
    logic [3:0]     a_nib_s;
    logic [3:0]     b_nib_s;
    logic [4:0]     stage_s;
    logic [W-1:0]   wrk_upd_s;

    assign accept_s   = (state_q != ST_ADD) && (REQ0 || REQ1);
    assign last_nib_s = (nidx_q == 3'(NIBBLES - 1));

    // Round-robin pick: a lone requester wins; on contention, the one not granted last wins.
    always_comb begin
        if (REQ0 && REQ1) begin
            win_s = ~rr_last_q;
        end else if (REQ1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Select the current nibble of the latched operands.
    always_comb begin
        a_nib_s = 4'h0;
        b_nib_s = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            a_nib_s = (nidx_q == 3'(i)) ? opa_q[4*i +: 4] : a_nib_s;
            b_nib_s = (nidx_q == 3'(i)) ? opb_q[4*i +: 4] : b_nib_s;
        end
    end

    // Single 4-bit ripple stage; bit 4 is the stage carry-out.
    assign stage_s = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, cr_q};

    // Working register with the current nibble replaced by the stage sum.
    always_comb begin
        wrk_upd_s = wrk_q;
        for (int i = 0; i < NIBBLES; i++) begin
            wrk_upd_s[4*i +: 4] = (nidx_q == 3'(i)) ? stage_s[3:0] : wrk_q[4*i +: 4];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        nidx_d    = nidx_q;
        cr_d      = cr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        wrk_d     = wrk_q;
        cur_d     = cur_q;
        rr_last_d = rr_last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        sum_d     = sum_q;
        cout_d    = cout_q;
        owner_d   = owner_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (accept_s) begin
                    opa_d     = win_s ? OPA1 : OPA0;
                    opb_d     = win_s ? OPB1 : OPB0;
                    cr_d      = win_s ? CIN1 : CIN0;
                    nidx_d    = 3'd0;
                    wrk_d     = {W{1'b0}};
                    cur_d     = win_s;
                    rr_last_d = win_s;
                    gnt0_d    = ~win_s;
                    gnt1_d    = win_s;
                    state_d   = ST_ADD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ADD: begin
                nidx_d = nidx_q + 3'd1;
                cr_d   = stage_s[4];
                wrk_d  = wrk_upd_s;
                if (last_nib_s) begin
                    sum_d   = wrk_upd_s;
                    cout_d  = stage_s[4];
                    owner_d = cur_q;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_ADD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            nidx_q    <= 3'd0;
            cr_q      <= 1'b0;
            opa_q     <= {W{1'b0}};
            opb_q     <= {W{1'b0}};
            wrk_q     <= {W{1'b0}};
            cur_q     <= 1'b0;
            rr_last_q <= 1'b1;      // "1 was last" so requester 0 is favoured
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= {W{1'b0}};
            cout_q    <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            nidx_q    <= nidx_d;
            cr_q      <= cr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            wrk_q     <= wrk_d;
            cur_q     <= cur_d;
            rr_last_q <= rr_last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            owner_q   <= owner_d;
        end
    end

`ifdef NIBBLE_ADD_SCHED_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_upd_s;

    // Carry into bit W-1 recovered from the top stage bits, XORed with the carry out.
    assign ovf_upd_s = (a_nib_s[3] ^ b_nib_s[3] ^ stage_s[3]) ^ stage_s[4];

    // Overflow updates only on the completing edge.
    always_comb begin
        if ((state_q == ST_ADD) && last_nib_s) begin
            ovf_d = ovf_upd_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign BUSY  = (state_q == ST_ADD);
    assign SUM   = sum_q;
    assign COUT  = cout_q;
    assign OWNER = owner_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_sched
//
// Self-checking bench for nibble_add_sched with NIBBLES=4. A transaction-level
// reference model computes each result with full-width arithmetic. It predicts
// GNT/BUSY/DONE from the grant cycle and the fixed latency, and tracks the
// round-robin pointer. All outputs are compared every cycle, on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_nibble_add_sched;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b1;
    logic         REQ0  = 1'b0;
    logic         REQ1  = 1'b0;
    logic         CIN0  = 1'b0;
    logic         CIN1  = 1'b0;
    logic [W-1:0] OPA0  = '0;
    logic [W-1:0] OPB0  = '0;
    logic [W-1:0] OPA1  = '0;
    logic [W-1:0] OPB1  = '0;
    logic         GNT0, GNT1, BUSY, COUT, OWNER, DONE;
    logic [W-1:0] SUM;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    logic         OVF;
`endif

    nibble_add_sched #(.NIBBLES(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ0  (REQ0),
        .OPA0  (OPA0),
        .OPB0  (OPB0),
        .CIN0  (CIN0),
        .REQ1  (REQ1),
        .OPA1  (OPA1),
        .OPB1  (OPB1),
        .CIN1  (CIN1),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .BUSY  (BUSY),
        .SUM   (SUM),
        .COUT  (COUT),
        .OWNER (OWNER),
        .DONE  (DONE)
`ifdef NIBBLE_ADD_SCHED_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int           g_cyc   = -1;     // cycle in which the current/last GNT is high
    logic         g_win   = 1'b0;
    logic         rr_last = 1'b1;
    logic [W-1:0] p_sum   = '0;
    logic         p_cout  = 1'b0;
    logic         p_ovf   = 1'b0;
    logic [W-1:0] e_sum   = '0;
    logic         e_cout  = 1'b0;
    logic         e_owner = 1'b0;
    logic         e_ovf   = 1'b0;

    // Observed DONE cycles/owners during the contention scenario
    int   done_cyc_q[$];
    logic done_own_q[$];
    logic record_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive inputs for one cycle, check outputs against the model, then advance.
    task automatic run_cycle(input logic r0, input logic r1,
                             input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                             input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1);
        logic       exp_busy;
        logic       exp_done;
        logic       w;
        logic [W:0] full;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       c;
        REQ0 = r0; OPA0 = a0; OPB0 = b0; CIN0 = c0;
        REQ1 = r1; OPA1 = a1; OPB1 = b1; CIN1 = c1;
        @(negedge CLK);
        exp_busy = (g_cyc >= 0) && (cyc >= g_cyc) && (cyc < g_cyc + N);
        exp_done = (g_cyc >= 0) && (cyc == g_cyc + N);
        if (exp_done) begin
            e_sum   = p_sum;
            e_cout  = p_cout;
            e_owner = g_win;
            e_ovf   = p_ovf;
        end
        chk("gnt0",  32'(GNT0),  32'((g_cyc == cyc) && !g_win));
        chk("gnt1",  32'(GNT1),  32'((g_cyc == cyc) && g_win));
        chk("busy",  32'(BUSY),  32'(exp_busy));
        chk("done",  32'(DONE),  32'(exp_done));
        chk("sum",   32'(SUM),   32'(e_sum));
        chk("cout",  32'(COUT),  32'(e_cout));
        chk("owner", 32'(OWNER), 32'(e_owner));
`ifdef NIBBLE_ADD_SCHED_OVF_EN
        chk("ovf",   32'(OVF),   32'(e_ovf));
`endif
        if (record_done && DONE) begin
            done_cyc_q.push_back(cyc);
            done_own_q.push_back(OWNER);
        end
        // Acceptance decision for the edge that ends this cycle
        if (((g_cyc < 0) || (cyc >= g_cyc + N)) && (r0 || r1)) begin
            w = (r0 && r1) ? ~rr_last : r1;
            a = w ? a1 : a0;
            b = w ? b1 : b0;
            c = w ? c1 : c0;
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            p_sum  = full[W-1:0];
            p_cout = full[W];
            p_ovf  = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
            g_cyc   = cyc + 1;
            g_win   = w;
            rr_last = w;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0,
                      W'($urandom), W'($urandom), 1'b0);
        end
    endtask

    // Assert reset now (asynchronously), check its effect, then release it on a falling edge.
    task automatic apply_reset(input int hold);
        RST_N = 1'b0;
        REQ0  = 1'b0;
        REQ1  = 1'b0;
        #1;
        chk("rst_gnt0",  32'(GNT0),  32'd0);
        chk("rst_gnt1",  32'(GNT1),  32'd0);
        chk("rst_busy",  32'(BUSY),  32'd0);
        chk("rst_done",  32'(DONE),  32'd0);
        chk("rst_sum",   32'(SUM),   32'd0);
        chk("rst_cout",  32'(COUT),  32'd0);
        chk("rst_owner", 32'(OWNER), 32'd0);
`ifdef NIBBLE_ADD_SCHED_OVF_EN
        chk("rst_ovf",   32'(OVF),   32'd0);
`endif
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        RST_N   = 1'b1;
        g_cyc   = -1;
        rr_last = 1'b1;
        e_sum   = '0;
        e_cout  = 1'b0;
        e_owner = 1'b0;
        e_ovf   = 1'b0;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        #2;
        apply_reset(3);
        idle(8);

        // Basic add by requester 0
        run_cycle(1'b1, 1'b0, 16'h1234, 16'h0FFF, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
        idle(N + 2);
        chk("basic_sum",   32'(SUM),   32'h0000_2234);
        chk("basic_cout",  32'(COUT),  32'd0);
        chk("basic_owner", 32'(OWNER), 32'd0);

        // Full carry chain by requester 1
        run_cycle(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        idle(N + 2);
        chk("chain_sum",   32'(SUM),   32'h0000_0000);
        chk("chain_cout",  32'(COUT),  32'd1);
        chk("chain_owner", 32'(OWNER), 32'd1);
`ifdef NIBBLE_ADD_SCHED_OVF_EN
        chk("chain_ovf",   32'(OVF),   32'd0);

        // Signed overflow, then hold through idle cycles
        run_cycle(1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0);
        idle(N + 6);
        chk("ovf_sum",  32'(SUM),  32'h0000_8000);
        chk("ovf_cout", 32'(COUT), 32'd0);
        chk("ovf_hold", 32'(OVF),  32'd1);
`endif

        // Contention from reset release: both held high
        apply_reset(2);
        record_done = 1'b1;
        for (int i = 0; i < 3 * (N + 1) + 1; i++) begin
            run_cycle(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom),
                      W'($urandom), W'($urandom), 1'($urandom));
        end
        record_done = 1'b0;
        idle(N + 2);
        chk("cont_ndone", 32'(done_cyc_q.size()), 32'd3);
        if (done_cyc_q.size() >= 3) begin
            chk("cont_own0",  32'(done_own_q[0]), 32'd0);
            chk("cont_own1",  32'(done_own_q[1]), 32'd1);
            chk("cont_own2",  32'(done_own_q[2]), 32'd0);
            chk("cont_gap01", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'(N + 1));
            chk("cont_gap12", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'(N + 1));
        end

        // Abort: reset while the third nibble (index 2) is being processed
        run_cycle(1'b1, 1'b0, 16'h4321, 16'h1111, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("abort_pre_busy", 32'(BUSY), 32'd1);
        apply_reset(1);
        idle(3 * N);

        // Randomised traffic with operands changing every cycle
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                      W'($urandom), W'($urandom), 1'($urandom),
                      W'($urandom), W'($urandom), 1'($urandom));
        end
        idle(N + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_add_sched.md
NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving operand width W = 4*NIBBLES and the number of nibble passes; legal values are 2..8.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port REQ0  input  1  requester 0 add request (level).
REQ-006 SHALL have port OPA0  input  W  requester 0 addend A.
REQ-007 SHALL have port OPB0  input  W  requester 0 addend B.
REQ-008 SHALL have port CIN0  input  1  requester 0 carry-in.
REQ-009 SHALL have ports REQ1, OPA1, OPB1, CIN1, with the same directions, widths and meanings for requester 1.
REQ-010 SHALL have port GNT0  output  1  one-cycle accept pulse for requester 0.
REQ-011 SHALL have port GNT1  output  1  one-cycle accept pulse for requester 1.
REQ-012 SHALL have port BUSY  output  1  high while a nibble pass is in progress.
REQ-013 SHALL have port SUM  output  W  result of the last completed add.
REQ-014 SHALL have port COUT  output  1  carry-out of the last completed add.
REQ-015 SHALL have port OWNER  output  1  requester index of the last completed add.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse marking SUM/COUT/OWNER updated.

Function
REQ-017 SHALL implement FSM states IDLE, ADD and FIN, plus a nibble index NIDX (3 bits) and a carry register CR.
REQ-018 In IDLE or FIN, SHALL at a clock edge with any REQ high:
- latch the winner's OPA, OPB and CIN (into CR);
- clear NIDX;
- pulse the matching GNT for the following cycle;
- enter ADD.
REQ-019 Arbitration SHALL be round-robin:
- a sole requester wins;
- when both request, the one not granted last wins;
- after reset, requester 0 has priority.
REQ-020 In ADD, each edge SHALL add latched nibble NIDX of A and B plus CR with a single 4-bit ripple adder stage, write the 4-bit sum into working-register nibble NIDX, load the stage carry-out into CR, and increment NIDX.
REQ-021 On the edge that processes nibble NIBBLES-1, SHALL:
- copy the working register to SUM, CR to COUT, and the winner index to OWNER;
- pulse DONE for one cycle;
- enter FIN.
REQ-022 FIN SHALL last one cycle, then return to IDLE unless a new request is accepted per REQ-018.
REQ-023 Latency SHALL be fixed: GNT high in cycle c implies DONE high in cycle c+NIBBLES; throughput is one add per NIBBLES+1 cycles.
REQ-024 BUSY SHALL equal (state == ADD); GNT0 and GNT1 SHALL never be high together.
REQ-025 SUM, COUT and OWNER SHALL change only on the DONE edge and SHALL hold between completions.
REQ-026 Requests SHALL be ignored while in ADD.
REQ-027 Operands SHALL be sampled only on the accept edge; later operand changes SHALL not affect the result.
REQ-028 A requester that keeps REQ high after its GNT pulse SHALL be treated as issuing a new request.
REQ-029 COUT SHALL be the carry out of bit W-1; the sum SHALL be modulo 2^W.

Reset
REQ-030 While RST_N is low, SHALL asynchronously force:
- state to IDLE, NIDX and CR to 0, and the round-robin pointer to favour requester 0;
- GNT0, GNT1, BUSY and DONE to 0;
- SUM to 0, COUT to 0 and OWNER to 0.
REQ-031 Reset during ADD SHALL abort the operation; no DONE SHALL follow release without a new accepted request.

Configuration
REQ-032 With macro NIBBLE_ADD_SCHED_OVF_EN defined, SHALL add port OVF  output  1  signed overflow (carry into bit W-1 XOR COUT), registered with SUM, reset 0, and held like SUM.
REQ-033 Without NIBBLE_ADD_SCHED_OVF_EN, SHALL have no OVF port and no overflow logic; all other behaviour SHALL be identical.

Verification (NIBBLES=4)
REQ-034 Reset check: RST_N low, then high with no REQ -> SUM=0x0000, COUT/OWNER/DONE/BUSY/GNT*=0 indefinitely.
REQ-035 Basic add: REQ0 with OPA0=0x1234, OPB0=0x0FFF, CIN0=1 -> GNT0 pulse in cycle c, BUSY high cycles c..c+3, DONE in c+4, SUM=0x2234, COUT=0, OWNER=0.
REQ-036 Carry chain: REQ1 with OPA1=0xFFFF, OPB1=0x0000, CIN1=1 -> SUM=0x0000, COUT=1, OWNER=1, OVF=0 (if enabled).
REQ-037 Contention: REQ0 and REQ1 held high from reset release -> GNT0 first; GNT1 in the first DONE cycle's edge successor; the next grant goes to requester 0; OWNER alternates 0,1,0 on successive DONEs spaced 5 cycles apart.
REQ-038 Abort: pulse RST_N low while NIDX=2 -> BUSY and DONE drop immediately, SUM=0x0000; with REQ low after release, DONE stays 0.
REQ-039 Overflow (macro defined): OPA0=0x7FFF, OPB0=0x0001, CIN0=0 -> SUM=0x8000, COUT=0, OVF=1; OVF holds through the following idle cycles.
